// File: rtl/npc_pkg.sv
// Shared NPC definitions: IFU state encoding, fault causes and architectural constants.
package npc_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_VALID    = 3'd3,
        S_WAIT_PC  = 3'd4
    } ifu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUS_ERR  = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_e;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Response timeout counter: expire pulses on the enabled cycle that brings the count to TIMEOUT.
module ifu_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare against TIMEOUT-1 so the fault lands on the cycle the count would reach TIMEOUT.
    generate
        if (TIMEOUT > 0) begin : g_expire
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            assign expire = en && (cnt_q == LAST);
        end else begin : g_no_expire
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-beat imem read, present word to decode, wait for next PC.
// Misaligned PCs, bus errors and response timeouts are turned into a fault-tagged NOP.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        IFU_done,
    input  logic        idu_ready,
    input  logic        pc_upd_valid,
    input  logic [31:0] pc_upd,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_cnt,
    output logic        proto_err
);

    ifu_state_e   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         fault_q, fault_d;
    fault_cause_e cause_q, cause_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         proto_err_q, proto_err_d;

    logic tmo_clr, tmo_en, tmo_expire;

    ifu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INST;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
            fetch_cnt_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            fetch_cnt_q <= fetch_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        fetch_cnt_d = fetch_cnt_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;
        proto_err_d = proto_err_q | (pc_upd_valid && (state_q != S_WAIT_PC));

        unique case (state_q)
            S_IDLE: begin
                tmo_clr = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    instr_d = NOP_INST;
                    fault_d = 1'b1;
                    cause_d = CAUSE_MISALIGN;
                    state_d = S_VALID;
                end else if (imem_req_ready) begin
                    tmo_clr = 1'b1;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A response on the expiry cycle takes priority over the timeout.
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        instr_d = NOP_INST;
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS_ERR;
                    end else begin
                        instr_d = imem_rsp_data;
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                    state_d = S_VALID;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expire) begin
                        instr_d = NOP_INST;
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                        state_d = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (idu_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (pc_upd_valid) begin
                    pc_d    = pc_upd;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        IFU_done       = 1'b0;
        if (state_q == S_REQ && pc_q[1:0] == 2'b00) begin
            imem_req_valid = 1'b1;
        end
        if (state_q == S_VALID) begin
            IFU_done = 1'b1;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign fetch_fault = fault_q;
    assign fault_cause = cause_q;
    assign fetch_cnt   = fetch_cnt_q;
    assign proto_err   = proto_err_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the multi-cycle NPC core, and the producer side of the fetch→decode handshake. It holds the PC and issues a single-beat read on the instruction-memory request/response bus. It presents the returned word to decode with IFU_done, then waits for the next-PC update from writeback before fetching again. Misaligned PCs, bus errors and response timeouts are converted into a fault-tagged NOP, so decode never stalls forever.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded at reset
TIMEOUT, 255, max cycles in WAIT_RSP before fault; 0 disables timeout
NOP_INST, 32'h0000_0013, word presented on fault (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  request address (= pc)
imem_rsp_valid  input  1  read data valid
imem_rsp_data  input  32  read data
imem_rsp_err  input  1  bus error, qualified by imem_rsp_valid
instruction  output  32  fetched word to decode, held stable while IFU_done=1
pc  output  32  address of the presented instruction
IFU_done  output  1  instruction valid to decode
idu_ready  input  1  decode consumed the instruction
pc_upd_valid  input  1  next PC available from writeback
pc_upd  input  32  next PC value
fetch_fault  output  1  presented word is a fault NOP; valid with IFU_done
fault_cause  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout
fetch_cnt  output  32  count of instructions handed to decode; wraps
proto_err  output  1  sticky: pc_upd_valid seen outside WAIT_PC

Behaviour:
- Reset (rst=0, async):
  - State IDLE, pc=RESET_PC.
  - instruction=NOP_INST; IFU_done, imem_req_valid, fetch_fault, proto_err = 0; fault_cause=0; fetch_cnt=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT_RSP, VALID, WAIT_PC.
- IDLE:
  - First clock after reset release goes to REQ unconditionally.
- REQ:
  - If pc[1:0]!=0: no request issued; load NOP_INST, fault=1, cause=1 → VALID.
  - Otherwise imem_req_valid=1, imem_addr=pc. When imem_req_ready=1 in the same cycle → WAIT_RSP and clear the timeout counter.
  - imem_req_valid and imem_addr stay stable until accepted.
- WAIT_RSP:
  - imem_req_valid=0.
  - On imem_rsp_valid: if imem_rsp_err, load NOP_INST with fault cause 2; else load imem_rsp_data with fault=0. Then → VALID.
  - Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, load NOP_INST with cause 3 → VALID.
  - A response arriving in the same cycle as the timeout wins (data captured, no fault).
- VALID:
  - IFU_done=1; instruction, pc, fetch_fault and fault_cause are held.
  - On idu_ready: IFU_done drops the next cycle, fetch_cnt increments (wraps 0xFFFF_FFFF→0) → WAIT_PC.
  - Request-to-IFU_done latency is 1 cycle after rsp_valid; minimum 3 cycles from REQ entry.
- WAIT_PC:
  - On pc_upd_valid: pc←pc_upd, clear fault → REQ. No range check; misalignment is caught in REQ.
- pc_upd_valid in any state other than WAIT_PC is ignored and sets proto_err. proto_err is cleared only by reset.
- imem responses arriving outside WAIT_RSP are ignored.
- Reset asserted mid-transaction abandons any outstanding request. A late response after reset release is dropped because the FSM is not in WAIT_RSP until it issues a new request.

Decomposition:
- Shared package (npc_pkg): FSM state enum, fault_cause encodings, NOP_INST and RESET_PC constants, for reuse by IDU and the difftest glue.
- Sub-module ifu_timeout_ctr: clear/enable/expire counter, width $clog2(TIMEOUT+1), expire tied low when TIMEOUT=0.
- Everything else stays in ifu_fetch.

Test Plan:
- Reset release, memory returns 32'h00100093 one cycle after request → imem_addr=0x80000000; IFU_done=1 with instruction=0x00100093, pc=0x80000000, fetch_fault=0.
- idu_ready held low 5 cycles, then pulsed; then pc_upd=0x80000004 → instruction stable for all 5 cycles; fetch_cnt 0→1; next imem_addr=0x80000004.
- pc_upd=0x80000006 → no imem_req_valid; IFU_done with instruction=0x00000013, fetch_fault=1, fault_cause=1.
- Response with imem_rsp_err=1 → NOP presented with cause 2. With TIMEOUT=4 and no response → fault cause 3 exactly 4 cycles after acceptance. Response on the expiry cycle → data presented, no fault.
- imem_req_ready low 3 cycles → req_valid and addr stable throughout; pc_upd_valid pulsed in VALID → ignored, proto_err=1 sticky.
- Assert rst while in WAIT_RSP, then deliver a late rsp_valid after release → outputs return to reset values; late response ignored; fresh fetch from 0x80000000.
